// File: rtl/race_join_ctrl.sv
// Purpose : N-channel fork/join controller; launches countdown workers and reports the join point.
// Latency : done is registered and pulses one cycle after the join edge; a worker of delay D finishes D edges after launch.
// Backpres: start is accepted only while idle (busy low); starts while busy are dropped without side effects.
// Optional watchdog: define RACE_TIMEOUT_EN to enable the TIMEOUT-cycle run watchdog.
module race_join_ctrl #(
   parameter int N       = 4,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [1:0]                    mode,
   input  logic [N-1:0]                  en,
   input  logic [N*CNT_W-1:0]            delay,
   input  logic [N-1:0]                  kill,
   output logic                          busy,
   output logic                          done,
   output logic                          winner_valid,
   output logic [(N>1?$clog2(N):1)-1:0]  winner_id,
   output logic [2*N-1:0]                status,
   output logic                          timeout
);

   localparam int IDW = (N > 1) ? $clog2(N) : 1;

   // Per-channel process-style state encoding, as seen on the status port.
   localparam logic [1:0] CH_IDLE = 2'd0;
   localparam logic [1:0] CH_RUN  = 2'd1;
   localparam logic [1:0] CH_FIN  = 2'd2;
   localparam logic [1:0] CH_KILL = 2'd3;

   // Join modes as latched at launch; the reserved code behaves as join-all.
   localparam logic [1:0] M_ANY  = 2'd1;
   localparam logic [1:0] M_NONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_JOINED = 2'd2
   } fsm_t;

   fsm_t                       state_q, state_d;
   logic [N-1:0][1:0]          st_q, st_d;
   logic [N-1:0][CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]                 mode_q, mode_d;
   logic                       done_q, done_d;
   logic                       wv_q, wv_d;
   logic [IDW-1:0]             wid_q, wid_d;

   // Channels finishing at this edge, and whether anything is still running after it.
   logic [N-1:0]               fin;
   logic                       any_run;

`ifdef RACE_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
   logic                       timeout_q, timeout_d;
   logic                       wd_fire;
`else
   logic                       unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

   // Next-state logic: launch, per-channel countdown, winner capture, join detection.
   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      wv_d    = wv_q;
      wid_d   = wid_q;
      fin     = '0;
      any_run = 1'b0;
`ifdef RACE_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
      timeout_d = timeout_q;
      wd_fire   = 1'b0;
`endif

      case (state_q)
         S_IDLE: begin
            if (start) begin
               for (int i = 0; i < N; i++) begin
                  if (en[i]) begin
                     st_d[i]  = CH_RUN;
                     // A zero delay still takes one edge to finish.
                     cnt_d[i] = (delay[i*CNT_W +: CNT_W] == '0) ? CNT_W'(1)
                                                                : delay[i*CNT_W +: CNT_W];
                  end else begin
                     st_d[i]  = CH_IDLE;
                     cnt_d[i] = '0;
                  end
               end
               mode_d = mode;
               wv_d   = 1'b0;
               wid_d  = '0;
`ifdef RACE_TIMEOUT_EN
               to_cnt_d  = '0;
               timeout_d = 1'b0;
`endif
               // Fire-and-forget runs, and runs with nothing enabled, join at launch.
               if (mode == M_NONE || en == '0) begin
                  done_d  = 1'b1;
                  state_d = S_JOINED;
               end else begin
                  state_d = S_RUN;
               end
            end
         end

         default: begin
            // Workers keep counting after the join so background (join-none) runs complete.
            for (int i = 0; i < N; i++) begin
               if (st_q[i] == CH_RUN) begin
                  if (kill[i]) begin
                     st_d[i]  = CH_KILL;
                     cnt_d[i] = '0;
                  end else if (cnt_q[i] == CNT_W'(1)) begin
                     st_d[i]  = CH_FIN;
                     cnt_d[i] = '0;
                     fin[i]   = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] - CNT_W'(1);
                  end
               end
            end

            // First finishing edge of the run names the winner; ties go to the lowest index.
            if (!wv_q && (fin != '0)) begin
               wv_d = 1'b1;
               for (int i = N - 1; i >= 0; i--) begin
                  if (fin[i]) begin
                     wid_d = IDW'(i);
                  end
               end
            end

            // Join-any: the first finisher(s) abort every other running worker.
            if (state_q == S_RUN && mode_q == M_ANY && (fin != '0)) begin
               for (int i = 0; i < N; i++) begin
                  if (st_d[i] == CH_RUN) begin
                     st_d[i] = CH_KILL;
                     cnt_d[i] = '0;
                  end
               end
            end

`ifdef RACE_TIMEOUT_EN
            // Watchdog: at the TIMEOUT-th edge after launch, kill whatever is still running.
            if (to_cnt_q != TO_W'(TIMEOUT - 1)) begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
            if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               for (int i = 0; i < N; i++) begin
                  if (st_d[i] == CH_RUN) begin
                     wd_fire  = 1'b1;
                     st_d[i]  = CH_KILL;
                     cnt_d[i] = '0;
                  end
               end
            end
            if (wd_fire) begin
               timeout_d = 1'b1;
            end
`endif

            for (int i = 0; i < N; i++) begin
               if (st_d[i] == CH_RUN) begin
                  any_run = 1'b1;
               end
            end

            // Every join flavour reduces to "nothing left running" once kills are applied.
            if (state_q == S_RUN) begin
               if (!any_run) begin
                  done_d  = 1'b1;
                  state_d = S_JOINED;
               end
            end else begin
               if (!any_run) begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   // State registers with synchronous reset; a reset mid-run drops the run silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         st_q    <= '0;
         cnt_q   <= '0;
         mode_q  <= '0;
         done_q  <= 1'b0;
         wv_q    <= 1'b0;
         wid_q   <= '0;
`ifdef RACE_TIMEOUT_EN
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         done_q  <= done_d;
         wv_q    <= wv_d;
         wid_q   <= wid_d;
`ifdef RACE_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign winner_valid = wv_q;
   assign winner_id    = wid_q;
   assign status       = st_q;
`ifdef RACE_TIMEOUT_EN
   assign timeout      = timeout_q;
`else
   assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_race_join_ctrl.sv
// Bench for race_join_ctrl: table of runs, expected results queued at launch.
// Each run is checked for join edge, done count, idle edge, final status and winner.
// Hand sequences cover reset state and reset in the middle of a run.
module tb_race_join_ctrl;
   localparam int N     = 4;
   localparam int CNT_W = 8;

   localparam logic [1:0] I = 2'd0;
   localparam logic [1:0] F = 2'd2;
   localparam logic [1:0] K = 2'd3;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [1:0]         mode;
   logic [N-1:0]       en;
   logic [N*CNT_W-1:0] delay;
   logic [N-1:0]       kill;
   logic               busy;
   logic               done;
   logic               winner_valid;
   logic [1:0]         winner_id;
   logic [2*N-1:0]     status;
   logic               timeout;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  en;
      logic [31:0] dly;    // {d3,d2,d1,d0}
      logic [3:0]  kmask;
      int          kedge;  // edge at which kmask is applied (0 = none)
      int          pedge;  // edge at which a stray start is driven (0 = none)
      int          jedge;  // expected join edge (done seen right after it)
      int          iedge;  // expected edge after which busy is low
      logic [7:0]  st;
      logic        wv;
      logic [1:0]  wid;
   } vec_t;

   vec_t vt[11];
   vec_t exp_q[$];

   race_join_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .mode         (mode),
      .en           (en),
      .delay        (delay),
      .kill         (kill),
      .busy         (busy),
      .done         (done),
      .winner_valid (winner_valid),
      .winner_id    (winner_id),
      .status       (status),
      .timeout      (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] st4(input logic [1:0] c0, input logic [1:0] c1,
                                      input logic [1:0] c2, input logic [1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   function automatic vec_t mkv(input logic [1:0] m, input logic [3:0] e, input logic [31:0] d,
                                input logic [3:0] km, input int ke, input int pe,
                                input int je, input int ie, input logic [7:0] s,
                                input logic w, input logic [1:0] wi);
      vec_t v;
      v.mode = m; v.en = e; v.dly = d; v.kmask = km; v.kedge = ke; v.pedge = pe;
      v.jedge = je; v.iedge = ie; v.st = s; v.wv = w; v.wid = wi;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      vec_t cur;
      bit   got   = 1'b0;
      int   k     = 0;
      int   ndone = 0;
      int   iseen = -1;
      cur = v;
      exp_q.push_back(v);
      @(negedge clk);
      start = 1'b1; mode = v.mode; en = v.en; delay = v.dly; kill = '0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (!got && exp_q.size() > 0) begin
               cur = exp_q.pop_front();
               got = 1'b1;
               chk("join_edge", k, cur.jedge);
            end
         end
         if (!busy) begin
            iseen = k;
            break;
         end
         if (k >= 400) break;
         kill = (k + 1 == v.kedge) ? v.kmask : '0;
         if (k + 1 == v.pedge) begin
            start = 1'b1; mode = 2'd1; en = '1; delay = {N{8'd1}};
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         k++;
      end
      start = 1'b0;
      kill  = '0;
      chk("done_seen", int'(got), 1);
      if (!got && exp_q.size() > 0) cur = exp_q.pop_front();
      chk("done_count", ndone, 1);
      chk("idle_edge", iseen, cur.iedge);
      chk("status", int'(status), int'(cur.st));
      chk("winner_valid", int'(winner_valid), int'(cur.wv));
      chk("winner_id", int'(winner_id), int'(cur.wid));
      chk("timeout", int'(timeout), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish, want completion");
      $fatal(1, "bench watchdog expired");
   end

   initial begin
      int nd;
      rst = 1'b1; start = 1'b0; mode = '0; en = '0; delay = '0; kill = '0;

      vt[0]  = mkv(2'd1, 4'hF, {8'd9, 8'd7, 8'd3, 8'd5}, 4'h0, 0, 0, 3,   4,   st4(K, F, K, K), 1'b1, 2'd1);
      vt[1]  = mkv(2'd1, 4'hF, {8'd6, 8'd2, 8'd2, 8'd4}, 4'h0, 0, 0, 2,   3,   st4(K, F, F, K), 1'b1, 2'd1);
      vt[2]  = mkv(2'd0, 4'hF, {8'd0, 8'd2, 8'd4, 8'd1}, 4'h0, 0, 0, 4,   5,   st4(F, F, F, F), 1'b1, 2'd0);
      vt[3]  = mkv(2'd2, 4'hF, {8'd2, 8'd2, 8'd2, 8'd9}, 4'h0, 0, 2, 0,   9,   st4(F, F, F, F), 1'b1, 2'd1);
      vt[4]  = mkv(2'd0, 4'hF, {8'd3, 8'd5, 8'd3, 8'd3}, 4'h4, 1, 0, 3,   4,   st4(F, F, K, F), 1'b1, 2'd0);
      vt[5]  = mkv(2'd0, 4'h0, {8'd1, 8'd1, 8'd1, 8'd1}, 4'h0, 0, 0, 0,   1,   st4(I, I, I, I), 1'b0, 2'd0);
      vt[6]  = mkv(2'd1, 4'hF, {8'd5, 8'd5, 8'd5, 8'd5}, 4'hF, 2, 0, 2,   3,   st4(K, K, K, K), 1'b0, 2'd0);
      vt[7]  = mkv(2'd3, 4'hA, {8'd1, 8'd0, 8'd2, 8'd0}, 4'h0, 0, 0, 2,   3,   st4(I, F, I, F), 1'b1, 2'd3);
      vt[8]  = mkv(2'd1, 4'hF, {8'd6, 8'd6, 8'd2, 8'd2}, 4'h1, 2, 0, 2,   3,   st4(K, F, K, K), 1'b1, 2'd1);
      vt[9]  = mkv(2'd0, 4'h1, {8'd0, 8'd0, 8'd0, 8'd255}, 4'h0, 0, 0, 255, 256, st4(F, I, I, I), 1'b1, 2'd0);
      vt[10] = mkv(2'd2, 4'hF, {8'd4, 8'd1, 8'd3, 8'd6}, 4'h1, 3, 0, 0,   4,   st4(K, F, F, F), 1'b1, 2'd2);

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_winner_valid", int'(winner_valid), 0);
      chk("rst_winner_id", int'(winner_id), 0);
      chk("rst_status", int'(status), 0);
      chk("rst_timeout", int'(timeout), 0);
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_vec(vt[i]);
      end

      // Reset in the middle of a join-all run: no done, everything back to idle.
      nd = 0;
      @(negedge clk);
      start = 1'b1; mode = 2'd0; en = 4'hF; delay = {4{8'd8}};
      @(posedge clk);               // E0
      @(negedge clk);
      start = 1'b0;
      if (done) nd++;
      @(posedge clk);               // E1
      @(negedge clk);
      if (done) nd++;
      rst = 1'b1;
      @(posedge clk);               // E2 with reset
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_status", int'(status), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_winner_valid", int'(winner_valid), 0);
      chk("midrst_done", int'(done), 0);
      repeat (12) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("midrst_no_done", nd, 0);

      // A fresh launch after the reset behaves normally.
      run_vec(vt[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
